// File: rtl/mips_pkg.sv
// mips_pkg: types and constants shared by the R-type encode and decode paths.
//   alu_op_t     - ALU operation code, also recovered by the pipeline controller
//   FUNCT_*      - R-type funct field values for each alu_op_t
//   OPCODE_RTYPE - opcode field common to every R-type instruction
//   NOP_WORD     - all-zero word (sll $0,$0,0) used as a hazard bubble
//   funct_of()   - alu_op_t -> funct lookup with a legality flag
package mips_pkg;

  typedef enum logic [2:0] {
    ADD = 3'd0,
    SUB = 3'd1,
    AND = 3'd2,
    OR  = 3'd3,
    SLT = 3'd4
  } alu_op_t;

  localparam logic [5:0]  OPCODE_RTYPE = 6'b000000;
  localparam logic [5:0]  FUNCT_ADD    = 6'b100000;
  localparam logic [5:0]  FUNCT_SUB    = 6'b100010;
  localparam logic [5:0]  FUNCT_AND    = 6'b100100;
  localparam logic [5:0]  FUNCT_OR     = 6'b100101;
  localparam logic [5:0]  FUNCT_SLT    = 6'b101010;
  localparam logic [31:0] NOP_WORD     = 32'h0000_0000;

  // Bit 6 of the result is the legal flag; bits 5:0 are the funct field.
  function automatic logic [6:0] funct_of(input logic [2:0] op);
    logic [6:0] r;
    case (op)
      3'd0:    r = {1'b1, FUNCT_ADD};
      3'd1:    r = {1'b1, FUNCT_SUB};
      3'd2:    r = {1'b1, FUNCT_AND};
      3'd3:    r = {1'b1, FUNCT_OR};
      3'd4:    r = {1'b1, FUNCT_SLT};
      default: r = 7'd0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/instr_encoder_rtype_pack.sv
// rtype_pack: combinational packer from ALU op and register fields to a
// 32-bit MIPS R-type word.
//   op    in  3 : alu_op_t encoding (0..4 legal)
//   rd    in  5 : destination register
//   rs    in  5 : first source register
//   rt    in  5 : second source register
//   word  out 32: {opcode, rs, rt, rd, shamt=0, funct}
//   legal out 1 : op is one of the five supported operations
module rtype_pack (
  input  logic [2:0]  op,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  output logic [31:0] word,
  output logic        legal
);
  import mips_pkg::*;

  logic [6:0] fl;

  always_comb begin
    fl    = funct_of(op);
    legal = fl[6];
    word  = {OPCODE_RTYPE, rs, rt, rd, 5'd0, fl[5:0]};
  end

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: accepts ALU-operation requests, encodes them as R-type words
// and writes them into instruction memory, each followed by NOP_GAP NOPs so
// the program runs on a pipeline without forwarding.
//   clk        in  1 : clock, rising edge
//   rst_n      in  1 : synchronous active-low reset
//   req_valid  in  1 : request present
//   req_ready  out 1 : request can be accepted this cycle
//   req_op     in  3 : 0 add, 1 sub, 2 and, 3 or, 4 slt (5..7 illegal)
//   req_rd/rs/rt in 5: register fields
//   imem_we    out 1 : write strobe, one word per cycle
//   imem_addr  out 32: byte address BASE_ADDR + 4*index
//   imem_wdata out 32: word being written
//   err        out 1 : one-cycle pulse after an illegal op is accepted
//   full       out 1 : DEPTH words written; sticky until reset
//   count      out $clog2(DEPTH)+1 : words written so far
module instr_encoder #(
  parameter int          DEPTH     = 256,
  parameter int          NOP_GAP   = 3,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [2:0]             req_op,
  input  logic [4:0]             req_rd,
  input  logic [4:0]             req_rs,
  input  logic [4:0]             req_rt,
  output logic                   imem_we,
  output logic [31:0]            imem_addr,
  output logic [31:0]            imem_wdata,
  output logic                   err,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);
  import mips_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;
  // Gap counter holds the NOPs still owed after the one being written.
  localparam int GW = (NOP_GAP > 1) ? $clog2(NOP_GAP) : 1;

  typedef enum logic [1:0] {IDLE, EMIT, PAD, FULL} state_t;

  state_t          state_q, state_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic [CW-1:0]   count_d;
  logic            we_d, err_d, full_d, ready_d;
  logic [31:0]     addr_d, wdata_d;

  logic [31:0]     pack_word;
  logic            pack_legal;
  logic [31:0]     wr_addr;
  logic [CW-1:0]   cnt_inc;
  logic            hit_depth;

  rtype_pack u_pack (
    .op    (req_op),
    .rd    (req_rd),
    .rs    (req_rs),
    .rt    (req_rt),
    .word  (pack_word),
    .legal (pack_legal)
  );

  assign wr_addr   = BASE_ADDR + (32'(count) << 2);
  assign cnt_inc   = count + CW'(1);
  assign hit_depth = (cnt_inc == CW'(DEPTH));

  // Every output is a register, so each state computes the values presented
  // in the following cycle: the handshake edge already loads the instruction
  // write, and the EMIT/PAD edges load the NOP writes that follow it.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    count_d = count;
    we_d    = 1'b0;
    addr_d  = imem_addr;
    wdata_d = imem_wdata;
    err_d   = 1'b0;
    full_d  = full;
    ready_d = 1'b0;
    case (state_q)
      IDLE: begin
        ready_d = (count < CW'(DEPTH));
        if (req_valid && req_ready) begin
          if (pack_legal) begin
            state_d = EMIT;
            we_d    = 1'b1;
            addr_d  = wr_addr;
            wdata_d = pack_word;
            count_d = cnt_inc;
            full_d  = hit_depth;
            ready_d = 1'b0;
          end else begin
            err_d   = 1'b1;
          end
        end
      end
      EMIT: begin
        if (full) begin
          state_d = FULL;
        end else if (NOP_GAP > 0) begin
          state_d = PAD;
          we_d    = 1'b1;
          addr_d  = wr_addr;
          wdata_d = NOP_WORD;
          count_d = cnt_inc;
          full_d  = hit_depth;
          gap_d   = GW'(NOP_GAP - 1);
        end else begin
          state_d = IDLE;
          ready_d = 1'b1;
        end
      end
      PAD: begin
        // Reaching capacity cuts the pad short; remaining NOPs are dropped.
        if (full) begin
          state_d = FULL;
        end else if (gap_q == '0) begin
          state_d = IDLE;
          ready_d = 1'b1;
        end else begin
          we_d    = 1'b1;
          addr_d  = wr_addr;
          wdata_d = NOP_WORD;
          count_d = cnt_inc;
          full_d  = hit_depth;
          gap_d   = gap_q - GW'(1);
        end
      end
      FULL: begin
        state_d = FULL;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      gap_q      <= '0;
      count      <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= BASE_ADDR;
      imem_wdata <= NOP_WORD;
      err        <= 1'b0;
      full       <= 1'b0;
      req_ready  <= 1'(DEPTH > 0);
    end else begin
      state_q    <= state_d;
      gap_q      <= gap_d;
      count      <= count_d;
      imem_we    <= we_d;
      imem_addr  <= addr_d;
      imem_wdata <= wdata_d;
      err        <= err_d;
      full       <= full_d;
      req_ready  <= ready_d;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;

  localparam int          A_DEPTH = 256;
  localparam int          A_GAP   = 3;
  localparam int          B_DEPTH = 6;
  localparam int          B_GAP   = 3;
  localparam int          C_DEPTH = 256;
  localparam int          C_GAP   = 0;
  localparam logic [31:0] C_BASE  = 32'h100;

  localparam logic [31:0] W_ADD = 32'h00221820; // add $3,$1,$2
  localparam logic [31:0] W_SUB = 32'h00A62022; // sub $4,$5,$6
  localparam logic [31:0] W_SLT = 32'h03FFF82A; // slt $31,$31,$31
  localparam logic [31:0] W_AND = 32'h01093824; // and $7,$8,$9
  localparam logic [31:0] W_OR  = 32'h016C5025; // or  $10,$11,$12

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          cnt;
    logic        full;
  } wr_t;

  wr_t a_q[$];
  wr_t b_q[$];
  wr_t c_q[$];
  int  a_cnt = 0;

  // DUT A: default depth, three NOPs of padding
  logic        a_rst_n, a_valid, a_ready, a_we, a_err, a_full;
  logic [2:0]  a_op;
  logic [4:0]  a_rd, a_rs, a_rt;
  logic [31:0] a_addr, a_wdata;
  logic [$clog2(A_DEPTH):0] a_count;

  // DUT B: tiny memory to reach capacity mid-pad
  logic        b_rst_n, b_valid, b_ready, b_we, b_err, b_full;
  logic [2:0]  b_op;
  logic [4:0]  b_rd, b_rs, b_rt;
  logic [31:0] b_addr, b_wdata;
  logic [$clog2(B_DEPTH):0] b_count;

  // DUT C: no padding, non-zero base address
  logic        c_rst_n, c_valid, c_ready, c_we, c_err, c_full;
  logic [2:0]  c_op;
  logic [4:0]  c_rd, c_rs, c_rt;
  logic [31:0] c_addr, c_wdata;
  logic [$clog2(C_DEPTH):0] c_count;

  instr_encoder #(.DEPTH(A_DEPTH), .NOP_GAP(A_GAP), .BASE_ADDR(32'h0)) u_a (
    .clk(clk), .rst_n(a_rst_n), .req_valid(a_valid), .req_ready(a_ready),
    .req_op(a_op), .req_rd(a_rd), .req_rs(a_rs), .req_rt(a_rt),
    .imem_we(a_we), .imem_addr(a_addr), .imem_wdata(a_wdata),
    .err(a_err), .full(a_full), .count(a_count));

  instr_encoder #(.DEPTH(B_DEPTH), .NOP_GAP(B_GAP), .BASE_ADDR(32'h0)) u_b (
    .clk(clk), .rst_n(b_rst_n), .req_valid(b_valid), .req_ready(b_ready),
    .req_op(b_op), .req_rd(b_rd), .req_rs(b_rs), .req_rt(b_rt),
    .imem_we(b_we), .imem_addr(b_addr), .imem_wdata(b_wdata),
    .err(b_err), .full(b_full), .count(b_count));

  instr_encoder #(.DEPTH(C_DEPTH), .NOP_GAP(C_GAP), .BASE_ADDR(C_BASE)) u_c (
    .clk(clk), .rst_n(c_rst_n), .req_valid(c_valid), .req_ready(c_ready),
    .req_op(c_op), .req_rd(c_rd), .req_rs(c_rs), .req_rt(c_rt),
    .imem_we(c_we), .imem_addr(c_addr), .imem_wdata(c_wdata),
    .err(c_err), .full(c_full), .count(c_count));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Queue one instruction plus `nops` NOPs for DUT A at the model's index.
  task automatic a_exp(input logic [31:0] w, input int nops);
    a_q.push_back('{32'(4 * a_cnt), w, a_cnt + 1, 1'b0});
    a_cnt++;
    for (int i = 0; i < nops; i++) begin
      a_q.push_back('{32'(4 * a_cnt), 32'h0, a_cnt + 1, 1'b0});
      a_cnt++;
    end
  endtask

  task automatic a_issue(input logic [2:0] op, input logic [4:0] rd, rs, rt);
    int n = 0;
    a_op = op; a_rd = rd; a_rs = rs; a_rt = rt; a_valid = 1'b1;
    while (!a_ready && n < 50) begin @(negedge clk); n++; end
    if (!a_ready) chk("a_accept_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
    a_valid = 1'b0;
  endtask

  // Count cycles from the handshake until req_ready returns.
  task automatic a_wait_done(input int exp_cycles);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        chk("a_we_latency", 32'(a_we), 32'd1);
        chk("a_err_legal", 32'(a_err), 32'd0);
      end
    end while (!a_ready && n < 50);
    chk("a_ready_cycles", 32'(n), 32'(exp_cycles));
  endtask

  task automatic b_issue(input logic [2:0] op, input logic [4:0] rd, rs, rt);
    int n = 0;
    b_op = op; b_rd = rd; b_rs = rs; b_rt = rt; b_valid = 1'b1;
    while (!b_ready && n < 50) begin @(negedge clk); n++; end
    if (!b_ready) chk("b_accept_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
    b_valid = 1'b0;
  endtask

  // Monitors: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (a_we) begin
      if (a_q.size() == 0) chk("a_unexpected_write", 32'd1, 32'd0);
      else begin
        wr_t e;
        e = a_q.pop_front();
        chk("a_addr", a_addr, e.addr);
        chk("a_data", a_wdata, e.data);
        chk("a_count", 32'(a_count), 32'(e.cnt));
        chk("a_full", 32'(a_full), 32'(e.full));
      end
    end
  end

  always @(negedge clk) begin
    if (b_we) begin
      if (b_q.size() == 0) chk("b_unexpected_write", 32'd1, 32'd0);
      else begin
        wr_t e;
        e = b_q.pop_front();
        chk("b_addr", b_addr, e.addr);
        chk("b_data", b_wdata, e.data);
        chk("b_count", 32'(b_count), 32'(e.cnt));
        chk("b_full", 32'(b_full), 32'(e.full));
      end
    end
  end

  always @(negedge clk) begin
    if (c_we) begin
      if (c_q.size() == 0) chk("c_unexpected_write", 32'd1, 32'd0);
      else begin
        wr_t e;
        e = c_q.pop_front();
        chk("c_addr", c_addr, e.addr);
        chk("c_data", c_wdata, e.data);
        chk("c_count", 32'(c_count), 32'(e.cnt));
        chk("c_full", 32'(c_full), 32'(e.full));
        chk("c_err", 32'(c_err), 32'd0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] cnt_before;
    a_rst_n = 1'b0; a_valid = 1'b0; a_op = '0; a_rd = '0; a_rs = '0; a_rt = '0;
    b_rst_n = 1'b0; b_valid = 1'b0; b_op = '0; b_rd = '0; b_rs = '0; b_rt = '0;
    c_rst_n = 1'b0; c_valid = 1'b0; c_op = '0; c_rd = '0; c_rs = '0; c_rt = '0;
    repeat (3) @(posedge clk);
    #1 a_rst_n = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_ready", 32'(a_ready), 32'd1);
    chk("rst_we", 32'(a_we), 32'd0);
    chk("rst_addr", a_addr, 32'h0);
    chk("rst_wdata", a_wdata, 32'h0);
    chk("rst_err", 32'(a_err), 32'd0);
    chk("rst_full", 32'(a_full), 32'd0);
    chk("rst_count", 32'(a_count), 32'd0);

    // Five legal ops, each followed by three NOPs
    a_exp(W_ADD, A_GAP); a_issue(3'd0, 5'd3, 5'd1, 5'd2); a_wait_done(A_GAP + 2);
    chk("add_count", 32'(a_count), 32'd4);
    a_exp(W_SUB, A_GAP); a_issue(3'd1, 5'd4, 5'd5, 5'd6); a_wait_done(A_GAP + 2);
    chk("sub_count", 32'(a_count), 32'd8);
    a_exp(W_SLT, A_GAP); a_issue(3'd4, 5'd31, 5'd31, 5'd31); a_wait_done(A_GAP + 2);
    chk("slt_count", 32'(a_count), 32'd12);
    a_exp(W_AND, A_GAP); a_issue(3'd2, 5'd7, 5'd8, 5'd9); a_wait_done(A_GAP + 2);
    a_exp(W_OR, A_GAP);  a_issue(3'd3, 5'd10, 5'd11, 5'd12); a_wait_done(A_GAP + 2);
    chk("or_count", 32'(a_count), 32'd20);

    // Illegal op: err pulse, no write, then add accepted immediately
    cnt_before = 32'(a_count);
    a_issue(3'd6, 5'd1, 5'd1, 5'd1);
    @(negedge clk);
    chk("illegal_err", 32'(a_err), 32'd1);
    chk("illegal_we", 32'(a_we), 32'd0);
    chk("illegal_ready", 32'(a_ready), 32'd1);
    chk("illegal_count", 32'(a_count), cnt_before);
    a_exp(W_ADD, A_GAP); a_issue(3'd0, 5'd3, 5'd1, 5'd2); a_wait_done(A_GAP + 2);
    chk("after_illegal_count", 32'(a_count), 32'd24);

    // Reset during the pad: instruction and one NOP written, rest abandoned
    a_exp(W_ADD, 1);
    a_issue(3'd0, 5'd3, 5'd1, 5'd2);
    @(posedge clk); #1 a_rst_n = 1'b0;
    @(posedge clk); #1 a_rst_n = 1'b1;
    a_cnt = 0;
    @(negedge clk);
    chk("midpad_we", 32'(a_we), 32'd0);
    chk("midpad_count", 32'(a_count), 32'd0);
    chk("midpad_ready", 32'(a_ready), 32'd1);
    chk("midpad_addr", a_addr, 32'h0);
    a_exp(W_SUB, A_GAP); a_issue(3'd1, 5'd4, 5'd5, 5'd6); a_wait_done(A_GAP + 2);
    chk("post_rst_count", 32'(a_count), 32'd4);

    // Capacity: DEPTH=6, second add truncated after one NOP
    @(posedge clk); #1 b_rst_n = 1'b1;
    b_q.push_back('{32'h00, W_ADD, 1, 1'b0});
    b_q.push_back('{32'h04, 32'h0, 2, 1'b0});
    b_q.push_back('{32'h08, 32'h0, 3, 1'b0});
    b_q.push_back('{32'h0C, 32'h0, 4, 1'b0});
    b_q.push_back('{32'h10, W_ADD, 5, 1'b0});
    b_q.push_back('{32'h14, 32'h0, 6, 1'b1});
    b_issue(3'd0, 5'd3, 5'd1, 5'd2);
    b_issue(3'd0, 5'd3, 5'd1, 5'd2);
    repeat (4) @(negedge clk);
    chk("cap_full", 32'(b_full), 32'd1);
    chk("cap_ready", 32'(b_ready), 32'd0);
    chk("cap_count", 32'(b_count), 32'd6);
    b_valid = 1'b1;
    repeat (20) @(negedge clk);
    chk("cap_third_ready", 32'(b_ready), 32'd0);
    chk("cap_third_count", 32'(b_count), 32'd6);
    chk("cap_third_full", 32'(b_full), 32'd1);
    b_valid = 1'b0;

    // No padding: valid held high, a write every other cycle from C_BASE
    @(negedge clk);
    chk("c_rst_addr", c_addr, C_BASE);
    chk("c_rst_ready", 32'(c_ready), 32'd1);
    @(posedge clk); #1;
    c_rst_n = 1'b1;
    for (int k = 0; k < 5; k++)
      c_q.push_back('{C_BASE + 32'(4 * k), W_ADD, k + 1, 1'b0});
    c_op = 3'd0; c_rd = 5'd3; c_rs = 5'd1; c_rt = 5'd2; c_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("c_ready_toggle", 32'(c_ready), (k % 2 == 0) ? 32'd1 : 32'd0);
    end
    @(posedge clk); #1 c_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("c_final_count", 32'(c_count), 32'd5);
    chk("c_final_full", 32'(c_full), 32'd0);

    repeat (3) @(negedge clk);
    chk("a_q_drained", 32'(a_q.size()), 32'd0);
    chk("b_q_drained", 32'(b_q.size()), 32'd0);
    chk("c_q_drained", 32'(c_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
